// File: rtl/reg_file.sv
// Register file, 2**AW x WIDTH: r0 reads zero, two combinational read ports, one write port.
// Writes land on the CLK edge (zero-cycle read; BYPASS=1 forwards Reg_In); never stalls, no flow control.
module reg_file #(
   parameter int WIDTH  = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RegW,
   input  logic [AW-1:0]    DR,
   input  logic [AW-1:0]    SR1,
   input  logic [AW-1:0]    SR2,
   input  logic [WIDTH-1:0] Reg_In,
   output logic [WIDTH-1:0] ReadReg1,
   output logic [WIDTH-1:0] ReadReg2
);

   localparam int NREG = 2 ** AW;

   // r0 has no storage; the array starts at index 1.
   logic [WIDTH-1:0] regs [1:NREG-1];
   logic             wr_hit;

   assign wr_hit = RegW && (DR != '0);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[DR] <= Reg_In;
      end
   end

   assign ReadReg1 = (SR1 == '0)                                  ? '0     :
                     ((BYPASS != 0) && wr_hit && (SR1 == DR))     ? Reg_In :
                                                                    regs[SR1];
   assign ReadReg2 = (SR2 == '0)                                  ? '0     :
                     ((BYPASS != 0) && wr_hit && (SR2 == DR))     ? Reg_In :
                                                                    regs[SR2];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: identical stimulus drives a BYPASS=0 and a BYPASS=1 instance.
module tb_reg_file;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        RegW = 1'b0;
   logic [4:0]  DR = '0;
   logic [4:0]  SR1 = '0;
   logic [4:0]  SR2 = '0;
   logic [31:0] Reg_In = '0;
   logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

   always #100 CLK = ~CLK;

   reg_file #(.WIDTH(32), .AW(5), .BYPASS(0)) u_nb (
      .CLK(CLK), .RST(RST), .RegW(RegW), .DR(DR), .SR1(SR1), .SR2(SR2),
      .Reg_In(Reg_In), .ReadReg1(rd1_nb), .ReadReg2(rd2_nb)
   );

   reg_file #(.WIDTH(32), .AW(5), .BYPASS(1)) u_bp (
      .CLK(CLK), .RST(RST), .RegW(RegW), .DR(DR), .SR1(SR1), .SR2(SR2),
      .Reg_In(Reg_In), .ReadReg1(rd1_bp), .ReadReg2(rd2_bp)
   );

   typedef struct {
      string       nm;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] b1;
      logic [31:0] b2;
   } exp_t;

   exp_t exp_q[$];
   event smp_ev;
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: pops every expectation posted for the current sample point.
   initial begin
      exp_t e;
      forever begin
         @(smp_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rd1_nb !== e.e1) begin
               miscompares++;
               $display("FAIL %s nb.ReadReg1 got %h want %h", e.nm, rd1_nb, e.e1);
            end
            if (rd2_nb !== e.e2) begin
               miscompares++;
               $display("FAIL %s nb.ReadReg2 got %h want %h", e.nm, rd2_nb, e.e2);
            end
            if (rd1_bp !== e.b1) begin
               miscompares++;
               $display("FAIL %s bp.ReadReg1 got %h want %h", e.nm, rd1_bp, e.b1);
            end
            if (rd2_bp !== e.b2) begin
               miscompares++;
               $display("FAIL %s bp.ReadReg2 got %h want %h", e.nm, rd2_bp, e.b2);
            end
         end
      end
   end

   // Sample in the current phase, without waiting for a clock edge.
   task automatic chk_now(input string nm, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] b1, input logic [31:0] b2);
      exp_t e;
      SR1 = s1;
      SR2 = s2;
      #1;
      e.nm = nm; e.e1 = e1; e.e2 = e2; e.b1 = b1; e.b2 = b2;
      exp_q.push_back(e);
      -> smp_ev;
      #1;
   endtask

   task automatic chk(input string nm, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] e1, input logic [31:0] e2);
      @(negedge CLK);
      chk_now(nm, s1, s2, e1, e2, e1, e2);
   endtask

   task automatic wr(input logic [4:0] d, input logic [31:0] v);
      @(negedge CLK);
      RegW = 1'b1;
      DR = d;
      Reg_In = v;
      @(negedge CLK);
      RegW = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held from time 0 across edges.
      @(negedge CLK);
      chk_now("rst_hold", 5'd5, 5'd31, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      chk("post_rst", 5'd1, 5'd30, 32'h0, 32'h0);

      // Write / readback.
      wr(5'd5, 32'hDEADBEEF);
      wr(5'd31, 32'h00000001);
      chk("rd_5_31", 5'd5, 5'd31, 32'hDEADBEEF, 32'h00000001);
      chk("rd_5_5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

      // Write enable low: r7 must stay zero.
      @(negedge CLK);
      RegW = 1'b0; DR = 5'd7; Reg_In = 32'h12345678;
      repeat (3) @(negedge CLK);
      chk("regw_gate", 5'd7, 5'd7, 32'h0, 32'h0);

      // Writes to r0 are dropped, including on the bypass path.
      @(negedge CLK);
      RegW = 1'b1; DR = 5'd0; Reg_In = 32'hFFFFFFFF;
      chk_now("r0_during", 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge CLK);
      RegW = 1'b0;
      chk("r0_after", 5'd0, 5'd0, 32'h0, 32'h0);

      // Same-cycle read/write of r9: old value vs write-through.
      wr(5'd9, 32'hA);
      @(negedge CLK);
      RegW = 1'b1; DR = 5'd9; Reg_In = 32'hB;
      chk_now("r9_during", 5'd9, 5'd5, 32'hA, 32'hDEADBEEF, 32'hB, 32'hDEADBEEF);
      @(negedge CLK);
      RegW = 1'b0;
      chk_now("r9_after", 5'd9, 5'd9, 32'hB, 32'hB, 32'hB, 32'hB);
      @(negedge CLK);
      RegW = 1'b1; DR = 5'd9; Reg_In = 32'hC;
      chk_now("r9_port2", 5'd5, 5'd9, 32'hDEADBEEF, 32'hB, 32'hDEADBEEF, 32'hC);
      @(negedge CLK);
      RegW = 1'b0;
      chk_now("r9_port2_after", 5'd5, 5'd9, 32'hDEADBEEF, 32'hC, 32'hDEADBEEF, 32'hC);

      // Reset coincident with a write edge: the write is lost.
      @(negedge CLK);
      RegW = 1'b1; DR = 5'd3; Reg_In = 32'h55;
      @(posedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      RegW = 1'b0;
      chk("rst_mid_wr", 5'd3, 5'd9, 32'h0, 32'h0);

      // Fill every writable register with its index.
      for (int i = 1; i < 32; i++) begin
         wr(i[4:0], i);
      end
      for (int i = 1; i < 32; i++) begin
         chk("fill", i[4:0], 5'(31 - i), i, 31 - i);
      end

      // Asynchronous reset mid-phase: all registers read zero before any edge.
      @(posedge CLK);
      #2;
      RST = 1'b1;
      for (int i = 0; i < 32; i++) begin
         chk_now("async_rst", i[4:0], 5'(31 - i), 32'h0, 32'h0, 32'h0, 32'h0);
      end
      @(negedge CLK);
      RST = 1'b0;

      // First write after reset release takes effect normally.
      wr(5'd4, 32'h00000004);
      chk("first_wr", 5'd4, 5'd31, 32'h4, 32'h0);

      @(negedge CLK);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain queue left %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
